// File: rtl/echo_multi_correlator_if.sv
`default_nettype none
// ============================================================================
// Module   : echo_multi_correlator_if
// Brief    : Start/config, FIFO read and result-readout signals of the
//            multi-echo correlator.
// Revision : 1.0  initial release
// ============================================================================
interface echo_multi_correlator_if #(
   parameter int DATA_W     = 12,
   parameter int CORR_W     = 18,
   parameter int IDX_W      = 20,
   parameter int MAX_ECHOES = 4
);
   localparam int SEL_W = (MAX_ECHOES > 1) ? $clog2(MAX_ECHOES) : 1;
   localparam int CNT_W = $clog2(MAX_ECHOES + 1);

   logic              sys_start_pulse;
   logic [DATA_W-1:0] fifo_q;
   logic              fifo_empty;
   logic              fifo_rdreq;
   logic [CORR_W-1:0] corr_threshold;
   logic [IDX_W-1:0]  blank_len;
   logic [SEL_W-1:0]  echo_sel;
   logic [IDX_W-1:0]  echo_tof;
   logic [CORR_W-1:0] echo_peak;
   logic [CNT_W-1:0]  echo_count;
   logic              echo_overflow;
   logic              hit_flag;
   logic              busy;
   logic              processing_done;

   modport master (
      input  sys_start_pulse, fifo_q, fifo_empty, corr_threshold, blank_len, echo_sel,
      output fifo_rdreq, echo_tof, echo_peak, echo_count, echo_overflow, hit_flag,
             busy, processing_done
   );

   modport slave (
      output sys_start_pulse, fifo_q, fifo_empty, corr_threshold, blank_len, echo_sel,
      input  fifo_rdreq, echo_tof, echo_peak, echo_count, echo_overflow, hit_flag,
             busy, processing_done
   );
endinterface
`default_nettype wire

// File: rtl/echo_multi_correlator.sv
`default_nettype none
// ============================================================================
// Module   : echo_multi_correlator
// Brief    : Windowed rectified-energy correlator recording up to MAX_ECHOES
//            (peak index, peak value) pairs with hysteresis and blanking.
// Revision : 1.0  initial release
// ============================================================================
module echo_multi_correlator #(
   parameter int DATA_W     = 12,
   parameter int WIN        = 64,
   parameter int CORR_W     = DATA_W + $clog2(WIN),
   parameter int IDX_W      = 20,
   parameter int DEPTH      = 20000,
   parameter int MAX_ECHOES = 4
) (
   input  logic                    clk_50M,
   input  logic                    rst_n,
   echo_multi_correlator_if.master bus
);
   localparam int c_win_aw  = $clog2(WIN);
   localparam int c_sel_w   = (MAX_ECHOES > 1) ? $clog2(MAX_ECHOES) : 1;
   localparam int c_cnt_w   = $clog2(MAX_ECHOES + 1);
   localparam logic [DATA_W-1:0]  c_mid      = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]   c_depth    = IDX_W'(DEPTH);
   localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0]   c_win      = IDX_W'(WIN);
   localparam logic [IDX_W-1:0]   c_idx_one  = IDX_W'(1);
   localparam logic [c_cnt_w-1:0] c_max_cnt  = c_cnt_w'(MAX_ECHOES);
   localparam logic [c_sel_w:0]   c_max_sel  = (c_sel_w + 1)'(MAX_ECHOES);

   typedef enum logic [1:0] {CTL_IDLE = 2'd0, CTL_RUN = 2'd1, CTL_FLUSH = 2'd2} ctl_state_t;
   typedef enum logic [1:0] {DET_ARMED = 2'd0, DET_IN_ECHO = 2'd1, DET_BLANK = 2'd2} det_state_t;

   ctl_state_t        r_ctl_state, w_ctl_nxt;
   det_state_t        r_det_state, w_det_nxt;
   logic              w_start, w_rdreq, w_done_nxt, r_done;
   logic [IDX_W-1:0]  r_reads, r_in_idx, r_a_idx, r_s_idx;
   logic              r_v1, r_v2, r_v3;
   logic [DATA_W-1:0] w_rect, r_a, w_old;
   logic [DATA_W-1:0] r_dline [WIN];
   logic [CORR_W-1:0] r_sum, r_thr, r_pk, w_pk_nxt;
   logic [IDX_W-1:0]  r_tof, w_tof_nxt, r_blank_len, r_blank_cnt, w_blank_nxt;
   logic              w_in_echo, w_commit, w_slot_we, w_last;
   logic [c_cnt_w-1:0] r_count;
   logic              r_overflow;
   logic [IDX_W-1:0]  r_slot_tof [MAX_ECHOES];
   logic [CORR_W-1:0] r_slot_pk  [MAX_ECHOES];
   logic [IDX_W-1:0]  r_tof_out;
   logic [CORR_W-1:0] r_peak_out;

   // ---------------------------------------------------------------- control
   always_comb begin
      w_ctl_nxt  = r_ctl_state;
      w_start    = 1'b0;
      w_rdreq    = 1'b0;
      w_done_nxt = 1'b0;
      case (r_ctl_state)
         CTL_IDLE: begin
            if (bus.sys_start_pulse) begin
               w_start   = 1'b1;
               w_ctl_nxt = CTL_RUN;
            end
         end
         CTL_RUN: begin
            w_rdreq = !bus.fifo_empty && (r_reads < c_depth);
            if (r_reads == c_depth) w_ctl_nxt = CTL_FLUSH;
         end
         CTL_FLUSH: begin
            if (!r_v1 && !r_v2 && !r_v3) begin
               w_done_nxt = 1'b1;
               w_ctl_nxt  = CTL_IDLE;
            end
         end
         default: w_ctl_nxt = CTL_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_ctl_state <= CTL_IDLE;
         r_done      <= 1'b0;
      end else begin
         r_ctl_state <= w_ctl_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // --------------------------------------------------- rectify / running sum
   assign w_rect = (bus.fifo_q >= c_mid) ? (bus.fifo_q - c_mid) : (c_mid - bus.fifo_q);
   assign w_old  = (r_a_idx >= c_win) ? r_dline[r_a_idx[c_win_aw-1:0]] : '0;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_reads  <= '0;
         r_in_idx <= '0;
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_v3     <= 1'b0;
         r_a      <= '0;
         r_a_idx  <= '0;
         r_sum    <= '0;
         r_s_idx  <= '0;
      end else begin
         r_v1 <= w_rdreq;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         if (w_start) begin
            r_reads  <= '0;
            r_in_idx <= '0;
            r_sum    <= '0;
         end else begin
            if (w_rdreq) r_reads  <= r_reads + c_idx_one;
            if (r_v1)    r_in_idx <= r_in_idx + c_idx_one;
            if (r_v2) begin
               r_sum   <= r_sum + CORR_W'(r_a) - CORR_W'(w_old);
               r_s_idx <= r_a_idx;
            end
         end
         if (r_v1) begin
            r_a     <= w_rect;
            r_a_idx <= r_in_idx;
         end
      end
   end

   // Stale delay-line contents are never read thanks to the n >= WIN guard.
   always_ff @(posedge clk_50M) begin
      if (r_v2) r_dline[r_a_idx[c_win_aw-1:0]] <= r_a;
   end

   // --------------------------------------------------------------- detector
   assign w_last    = (r_s_idx == c_last_idx);
   assign w_slot_we = w_commit && (r_count < c_max_cnt);

   always_comb begin
      w_det_nxt   = r_det_state;
      w_pk_nxt    = r_pk;
      w_tof_nxt   = r_tof;
      w_blank_nxt = r_blank_cnt;
      w_in_echo   = 1'b0;
      w_commit    = 1'b0;
      if (r_v3) begin
         case (r_det_state)
            DET_ARMED: begin
               if (r_sum >= r_thr) begin
                  w_in_echo = 1'b1;
                  w_pk_nxt  = r_sum;
                  w_tof_nxt = r_s_idx;
               end
            end
            DET_IN_ECHO: begin
               w_in_echo = 1'b1;
               if (r_sum > r_pk) begin
                  w_pk_nxt  = r_sum;
                  w_tof_nxt = r_s_idx;
               end
            end
            DET_BLANK: begin
               if (r_blank_cnt <= c_idx_one) w_det_nxt   = DET_ARMED;
               else                          w_blank_nxt = r_blank_cnt - c_idx_one;
            end
            default: w_det_nxt = DET_ARMED;
         endcase
         // An echo still open on the final sample is committed as-is.
         if (w_in_echo) begin
            if ((r_sum < r_thr) || w_last) begin
               w_commit = 1'b1;
               if (r_blank_len == '0) begin
                  w_det_nxt = DET_ARMED;
               end else begin
                  w_det_nxt   = DET_BLANK;
                  w_blank_nxt = r_blank_len;
               end
            end else begin
               w_det_nxt = DET_IN_ECHO;
            end
         end
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_det_state <= DET_ARMED;
         r_pk        <= '0;
         r_tof       <= '0;
         r_blank_cnt <= '0;
         r_thr       <= '0;
         r_blank_len <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
      end else if (w_start) begin
         r_det_state <= DET_ARMED;
         r_pk        <= '0;
         r_tof       <= '0;
         r_blank_cnt <= '0;
         r_thr       <= bus.corr_threshold;
         r_blank_len <= bus.blank_len;
         r_count     <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_det_state <= w_det_nxt;
         r_pk        <= w_pk_nxt;
         r_tof       <= w_tof_nxt;
         r_blank_cnt <= w_blank_nxt;
         if (w_slot_we)     r_count    <= r_count + c_cnt_w'(1);
         else if (w_commit) r_overflow <= 1'b1;
      end
   end

   // ---------------------------------------------------------- result slots
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_ECHOES; i++) begin
            r_slot_tof[i] <= '0;
            r_slot_pk[i]  <= '0;
         end
      end else if (w_start) begin
         for (int i = 0; i < MAX_ECHOES; i++) begin
            r_slot_tof[i] <= '0;
            r_slot_pk[i]  <= '0;
         end
      end else if (w_slot_we) begin
         r_slot_tof[r_count[c_sel_w-1:0]] <= w_tof_nxt;
         r_slot_pk[r_count[c_sel_w-1:0]]  <= w_pk_nxt;
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_tof_out  <= '0;
         r_peak_out <= '0;
      end else if ({1'b0, bus.echo_sel} < c_max_sel) begin
         r_tof_out  <= r_slot_tof[bus.echo_sel];
         r_peak_out <= r_slot_pk[bus.echo_sel];
      end else begin
         r_tof_out  <= '0;
         r_peak_out <= '0;
      end
   end

   assign bus.fifo_rdreq      = w_rdreq;
   assign bus.echo_tof        = r_tof_out;
   assign bus.echo_peak       = r_peak_out;
   assign bus.echo_count      = r_count;
   assign bus.echo_overflow   = r_overflow;
   assign bus.hit_flag        = (r_count != '0);
   assign bus.busy            = (r_ctl_state != CTL_IDLE);
   assign bus.processing_done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_echo_multi_correlator.sv
`default_nettype none
// ============================================================================
// Module   : tb_echo_multi_correlator
// Brief    : Directed self-checking bench for echo_multi_correlator (DEPTH=2000).
// Revision : 1.0  initial release
// ============================================================================
module tb_echo_multi_correlator;
   localparam int DEPTH = 2000;
   localparam logic [11:0] MID = 12'd2048;
   localparam logic [11:0] HI  = 12'd2148;
   localparam logic [11:0] LO  = 12'd1948;

   logic clk_50M = 1'b0;
   logic rst_n   = 1'b0;
   always #10 clk_50M = ~clk_50M;

   echo_multi_correlator_if #(.DATA_W(12), .CORR_W(18), .IDX_W(20), .MAX_ECHOES(4)) bus ();

   echo_multi_correlator #(
      .DATA_W(12), .WIN(64), .CORR_W(18), .IDX_W(20), .DEPTH(DEPTH), .MAX_ECHOES(4)
   ) dut (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [11:0] mem [DEPTH];
   int rd_ptr = 0;
   bit stall_en = 1'b0;
   int cyc = 0;
   int t_last = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic busy_at_done = 1'b0;

   // FIFO model: data appears the cycle after a read request
   initial begin
      logic [11:0] v;
      bit pend;
      bus.fifo_q     = '0;
      bus.fifo_empty = 1'b0;
      forever begin
         @(posedge clk_50M);
         cyc++;
         pend = 1'b0;
         if (bus.fifo_rdreq === 1'b1) begin
            v = (rd_ptr < DEPTH) ? mem[rd_ptr] : MID;
            rd_ptr++;
            t_last = cyc;
            pend = 1'b1;
         end
         #1;
         if (pend) bus.fifo_q = v;
         bus.fifo_empty = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
   end

   initial begin
      forever begin
         @(negedge clk_50M);
         if (bus.processing_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc + 1;
            busy_at_done = bus.busy;
         end
      end
   end

   task automatic fill_mid();
      for (int i = 0; i < DEPTH; i++) mem[i] = MID;
   endtask

   task automatic burst(input int s, input int len, input logic [11:0] v);
      for (int i = s; i < s + len; i++) mem[i] = v;
   endtask

   task automatic run_acq(input int blank, input bit stall, input bit poke_start);
      int guard;
      bus.corr_threshold = 18'd4500;
      bus.blank_len      = 20'(blank);
      stall_en           = stall;
      rd_ptr             = 0;
      done_cnt           = 0;
      @(negedge clk_50M); bus.sys_start_pulse = 1'b1;
      @(negedge clk_50M); bus.sys_start_pulse = 1'b0;
      guard = 0;
      while (done_cnt == 0 && guard < 6 * DEPTH) begin
         @(negedge clk_50M);
         guard++;
         bus.sys_start_pulse = (poke_start && guard == DEPTH / 2);
      end
      bus.sys_start_pulse = 1'b0;
      stall_en = 1'b0;
      repeat (20) @(negedge clk_50M);
   endtask

   task automatic read_slot(input int sel, output logic [19:0] tof, output logic [17:0] pk);
      @(negedge clk_50M); bus.echo_sel = 2'(sel);
      @(negedge clk_50M); tof = bus.echo_tof; pk = bus.echo_peak;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_50M);
      n_cmp++; if (bus.fifo_rdreq !== 1'b0 || bus.busy !== 1'b0 || bus.processing_done !== 1'b0) begin
         n_bad++; $display("FAIL reset_ctl: rdreq/busy/done got %b%b%b expected 000", bus.fifo_rdreq, bus.busy, bus.processing_done); end
      n_cmp++; if (bus.echo_count !== 3'd0 || bus.hit_flag !== 1'b0 || bus.echo_overflow !== 1'b0) begin
         n_bad++; $display("FAIL reset_res: count/hit/ovf got %0d/%b/%b expected 0/0/0", bus.echo_count, bus.hit_flag, bus.echo_overflow); end
      n_cmp++; if (bus.echo_tof !== 20'd0 || bus.echo_peak !== 18'd0) begin
         n_bad++; $display("FAIL reset_slot: tof/peak got %0d/%0d expected 0/0", bus.echo_tof, bus.echo_peak); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk_50M);
   endtask

   task automatic test_quiet();
      fill_mid();
      run_acq(0, 1'b0, 1'b0);
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL quiet_done: got %0d pulses expected 1", done_cnt); end
      n_cmp++; if (done_cyc - t_last !== 5) begin n_bad++; $display("FAIL quiet_latency: got %0d expected 5", done_cyc - t_last); end
      n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL quiet_busy: got %b expected 0", busy_at_done); end
      n_cmp++; if (rd_ptr !== DEPTH) begin n_bad++; $display("FAIL quiet_reads: got %0d expected %0d", rd_ptr, DEPTH); end
      n_cmp++; if (bus.echo_count !== 3'd0 || bus.hit_flag !== 1'b0 || bus.echo_overflow !== 1'b0) begin
         n_bad++; $display("FAIL quiet_res: count/hit/ovf got %0d/%b/%b expected 0/0/0", bus.echo_count, bus.hit_flag, bus.echo_overflow); end
   endtask

   task automatic test_single(input logic [11:0] level);
      logic [19:0] tof;
      logic [17:0] pk;
      fill_mid();
      burst(1000, 200, level);
      run_acq(0, 1'b0, 1'b0);
      n_cmp++; if (bus.echo_count !== 3'd1 || bus.hit_flag !== 1'b1 || bus.echo_overflow !== 1'b0) begin
         n_bad++; $display("FAIL single_%0d_res: count/hit/ovf got %0d/%b/%b expected 1/1/0", level, bus.echo_count, bus.hit_flag, bus.echo_overflow); end
      read_slot(0, tof, pk);
      n_cmp++; if (tof !== 20'd1063 || pk !== 18'd6400) begin
         n_bad++; $display("FAIL single_%0d_slot0: tof/peak got %0d/%0d expected 1063/6400", level, tof, pk); end
      read_slot(1, tof, pk);
      n_cmp++; if (tof !== 20'd0 || pk !== 18'd0) begin
         n_bad++; $display("FAIL single_%0d_slot1: tof/peak got %0d/%0d expected 0/0", level, tof, pk); end
   endtask

   task automatic test_blanking();
      logic [19:0] tof;
      logic [17:0] pk;
      // First echo closes at n=1219; second burst is above threshold for n=1444..1518
      fill_mid();
      burst(1000, 200, HI);
      burst(1400, 100, HI);
      run_acq(300, 1'b0, 1'b0);
      n_cmp++; if (bus.echo_count !== 3'd1) begin n_bad++; $display("FAIL blank300_count: got %0d expected 1", bus.echo_count); end
      run_acq(100, 1'b0, 1'b0);
      n_cmp++; if (bus.echo_count !== 3'd2) begin n_bad++; $display("FAIL blank100_count: got %0d expected 2", bus.echo_count); end
      read_slot(1, tof, pk);
      n_cmp++; if (tof !== 20'd1463 || pk !== 18'd6400) begin
         n_bad++; $display("FAIL blank100_slot1: tof/peak got %0d/%0d expected 1463/6400", tof, pk); end
   endtask

   task automatic test_overflow();
      logic [19:0] tof;
      logic [17:0] pk;
      fill_mid();
      for (int b = 0; b < 6; b++) burst(100 + 300 * b, 100, HI);
      run_acq(0, 1'b0, 1'b0);
      n_cmp++; if (bus.echo_count !== 3'd4 || bus.echo_overflow !== 1'b1 || bus.hit_flag !== 1'b1) begin
         n_bad++; $display("FAIL ovf_res: count/ovf/hit got %0d/%b/%b expected 4/1/1", bus.echo_count, bus.echo_overflow, bus.hit_flag); end
      for (int s = 0; s < 4; s++) begin
         read_slot(s, tof, pk);
         n_cmp++; if (tof !== 20'(163 + 300 * s) || pk !== 18'd6400) begin
            n_bad++; $display("FAIL ovf_slot%0d: tof/peak got %0d/%0d expected %0d/6400", s, tof, pk, 163 + 300 * s); end
      end
   endtask

   task automatic test_end_stall();
      logic [19:0] tof;
      logic [17:0] pk;
      fill_mid();
      burst(DEPTH - 50, 50, HI);
      run_acq(0, 1'b1, 1'b1);
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL end_done: got %0d pulses expected 1", done_cnt); end
      n_cmp++; if (done_cyc - t_last !== 5) begin n_bad++; $display("FAIL end_latency: got %0d expected 5", done_cyc - t_last); end
      n_cmp++; if (bus.echo_count !== 3'd1) begin n_bad++; $display("FAIL end_count: got %0d expected 1", bus.echo_count); end
      read_slot(0, tof, pk);
      n_cmp++; if (tof !== 20'(DEPTH - 1) || pk !== 18'd5000) begin
         n_bad++; $display("FAIL end_slot0: tof/peak got %0d/%0d expected %0d/5000", tof, pk, DEPTH - 1); end
   endtask

   task automatic test_reset_mid();
      fill_mid();
      burst(DEPTH - 50, 50, HI);
      bus.corr_threshold = 18'd4500;
      bus.blank_len      = 20'd0;
      stall_en = 1'b1;
      rd_ptr   = 0;
      done_cnt = 0;
      @(negedge clk_50M); bus.sys_start_pulse = 1'b1;
      @(negedge clk_50M); bus.sys_start_pulse = 1'b0;
      repeat (500) @(negedge clk_50M);
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b expected 1", bus.busy); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.fifo_rdreq !== 1'b0 || bus.processing_done !== 1'b0) begin
         n_bad++; $display("FAIL midrst_ctl: busy/rdreq/done got %b%b%b expected 000", bus.busy, bus.fifo_rdreq, bus.processing_done); end
      n_cmp++; if (bus.echo_count !== 3'd0 || bus.hit_flag !== 1'b0 || bus.echo_tof !== 20'd0 || bus.echo_peak !== 18'd0) begin
         n_bad++; $display("FAIL midrst_res: count/hit/tof/peak got %0d/%b/%0d/%0d expected 0/0/0/0", bus.echo_count, bus.hit_flag, bus.echo_tof, bus.echo_peak); end
      repeat (2) @(negedge clk_50M);
      rst_n = 1'b1;
      stall_en = 1'b0;
      repeat (DEPTH + 200) @(negedge clk_50M);
      n_cmp++; if (done_cnt !== 0 || bus.busy !== 1'b0) begin
         n_bad++; $display("FAIL midrst_after: done pulses/busy got %0d/%b expected 0/0", done_cnt, bus.busy); end
   endtask

   task automatic test_back_to_back();
      logic [19:0] tof;
      logic [17:0] pk;
      fill_mid();
      burst(1000, 200, HI);
      run_acq(0, 1'b0, 1'b0);
      n_cmp++; if (done_cnt !== 1 || bus.echo_count !== 3'd1) begin
         n_bad++; $display("FAIL recover_res: done/count got %0d/%0d expected 1/1", done_cnt, bus.echo_count); end
      read_slot(0, tof, pk);
      n_cmp++; if (tof !== 20'd1063 || pk !== 18'd6400) begin
         n_bad++; $display("FAIL recover_slot0: tof/peak got %0d/%0d expected 1063/6400", tof, pk); end
   endtask

   initial begin
      bus.sys_start_pulse = 1'b0;
      bus.corr_threshold  = 18'd4500;
      bus.blank_len       = 20'd0;
      bus.echo_sel        = 2'd0;
      test_reset();
      test_quiet();
      test_single(HI);
      test_single(LO);
      test_blanking();
      test_overflow();
      test_end_stall();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/echo_multi_correlator.md
# echo_multi_correlator

Parametrised multi-echo successor to the single-echo correlator in the ultrasound receive path. It drains ADC samples from the acquisition FIFO after `sys_start_pulse` and forms a windowed rectified-energy correlation. It then records up to `MAX_ECHOES` echoes as (peak index, peak value) pairs, with threshold hysteresis and a programmable blanking interval. Downstream ToF logic reads the results through a select port.

## Interface
- `DATA_W`, 12: ADC sample width, unsigned offset-binary.
- `WIN`, 64: correlation window length in samples; power of two, ≥ 2.
- `CORR_W`, `DATA_W+$clog2(WIN)` (18): correlation/threshold width.
- `IDX_W`, 20: sample-index width.
- `DEPTH`, 20000: samples consumed per acquisition, < 2^IDX_W.
- `MAX_ECHOES`, 4: result slots.
- `clk_50M`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sys_start_pulse`  in  1  one-cycle acquisition start.
- `fifo_q`  in  DATA_W  FIFO read data, valid the cycle after `fifo_rdreq`.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_rdreq`  out  1  FIFO read request.
- `corr_threshold`  in  CORR_W  detection threshold; sampled at start.
- `blank_len`  in  IDX_W  samples ignored after an echo closes; sampled at start.
- `echo_sel`  in  $clog2(MAX_ECHOES)  result slot select.
- `echo_tof`  out  IDX_W  peak sample index of the selected slot.
- `echo_peak`  out  CORR_W  peak correlation of the selected slot.
- `echo_count`  out  $clog2(MAX_ECHOES+1)  echoes recorded.
- `echo_overflow`  out  1  an echo was detected with all slots full.
- `hit_flag`  out  1  `echo_count != 0`.
- `busy`  out  1  acquisition in progress.
- `processing_done`  out  1  one-cycle pulse at end of acquisition.

## Operation
- Control FSM IDLE→RUN→FLUSH→IDLE.
  - IDLE: `sys_start_pulse` clears all slots, count, overflow, index and read counter. It latches the threshold and `blank_len`, then moves to RUN.
  - RUN: `fifo_rdreq = !fifo_empty && reads < DEPTH`. After `DEPTH` reads, move to FLUSH.
  - FLUSH: wait until the pipeline is empty, pulse `processing_done`, return to IDLE.
  - `sys_start_pulse` is ignored outside IDLE.
- Sample n (n = 0 for the first read) is processed as follows.
  - Rectify: `a = |x − 2^(DATA_W−1)|` (DATA_W bits).
  - Running sum: `S_n = S_{n−1} + a_n − (n ≥ WIN ? a_{n−WIN} : 0)`. A WIN-deep circular delay line holds past `a` values; no clear is needed because of the n ≥ WIN guard. S is exact and cannot overflow at CORR_W.
- Detector FSM ARMED / IN_ECHO / BLANK.
  - ARMED: if `S ≥ thr`, go to IN_ECHO with pk=S, tof=n.
  - IN_ECHO: if `S > pk` (strict, so the first maximum wins), update pk and tof. If `S < thr`, commit the echo.
    - Commit: write the slot if `count < MAX_ECHOES`, else set `echo_overflow`.
    - Then go to BLANK with counter = `blank_len`; if `blank_len = 0`, go straight to ARMED.
  - BLANK: decrement once per sample; at 0, go to ARMED. Samples in BLANK never open an echo.
- End of acquisition: if IN_ECHO when sample DEPTH−1 is processed, commit the open echo, then pulse done.
- Results hold until the next start. Unwritten slots read 0.

## Timing
- Reset value of every output is 0, and the FSMs go to IDLE/ARMED.
- Reset mid-acquisition aborts immediately with no `processing_done`. The FIFO contents are not flushed by this block.
- Pipeline stages:
  - rdreq at cycle t.
  - `fifo_q` captured at t+1.
  - `a` registered at t+2.
  - `S` registered at t+3.
  - Detector/slot update at t+4.
- `processing_done` is asserted at cycle t_last+5, where t_last is the cycle of the final rdreq. `busy` deasserts in the same cycle.
- `fifo_empty` stalls insert bubbles only; results are identical to an unstalled run.
- `echo_count`, `hit_flag` and `echo_overflow` update in the cycle after the commit.
- `echo_tof`/`echo_peak` are registered: valid one cycle after an `echo_sel` change or a slot write.
- Throughput: 1 sample/cycle sustained.

## Test plan
Defaults apply, thr=4500, `blank_len`=0, MID=2048.
- All samples 2048 → `processing_done` once, count 0, `hit_flag` 0, overflow 0.
- Samples 2148 at n=1000..1199, else 2048 → count 1, slot0 tof=1063, peak=6400; echo closes at n=1219.
- Same burst at 1948 (below MID) → identical result, proving rectification.
- Bursts of 2148 at n=1000 and n=1400, `blank_len`=300 → count 1. With `blank_len`=100 → count 2, slot1 tof=1463.
- Six separated bursts, MAX_ECHOES=4 → count 4, overflow 1, slots 0–3 in arrival order.
- Burst over n=19950..19999 (50 samples) with random `fifo_empty` stalls → committed at end, tof=19999, peak=5000, done exactly once. Repeat with `rst_n` pulsed mid-run → all outputs 0, no done.
